vload_resp_tracker: RTL and testbench

Tracks outstanding vector-lane load requests between issue and the data memory, and pairs each in-order read response with its saved address bits, size, sign-extend flag and destination tag. Entries are presented in issue order, with valid/ready flow control, to the downstream `vload_data_translator` stage, which does the byte/halfword alignment and extension. The memory return path has no backpressure, so the block reserves a buffer slot at issue time. Every accepted request is therefore guaranteed a slot for its response.

---
 rtl/vload_resp_tracker_pkg.sv | 17 +
 rtl/vload_tracker_ram.sv | 42 ++++
 rtl/vload_resp_tracker.sv | 103 ++++++++++
 tb/tb_vload_resp_tracker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vload_resp_tracker_pkg.sv
// Shared load-size encodings and metadata field widths for the vector load path
// (issue logic, response tracker and data translator).
package vload_resp_tracker_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    LOAD_BYTE = 2'b00,
    LOAD_HALF = 2'b01,
    LOAD_WORD = 2'b10
  } load_size_e;

  // addr + size + signext; the tag width is a per-instance parameter
  localparam int unsigned META_FIXED_W = ADDR_W + SIZE_W + 1;

endpackage

// File: rtl/vload_tracker_ram.sv
// Response tracker storage: DEPTH entries of load metadata plus read data,
// independent metadata/data write ports and an asynchronous head read.
module vload_tracker_ram
  import vload_resp_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PTRW  = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic              clk,
  input  logic              meta_we,
  input  logic [PTRW-1:0]   meta_idx,
  input  logic [ADDR_W-1:0] meta_addr,
  input  logic [SIZE_W-1:0] meta_size,
  input  logic              meta_signext,
  input  logic [TAGW-1:0]   meta_tag,
  input  logic              data_we,
  input  logic [PTRW-1:0]   data_idx,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [PTRW-1:0]   rd_idx,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SIZE_W-1:0] rd_size,
  output logic              rd_signext,
  output logic [TAGW-1:0]   rd_tag
);

  localparam int unsigned DEPTH  = 1 << PTRW;
  localparam int unsigned META_W = META_FIXED_W + TAGW;

  logic [META_W-1:0] meta_mem [DEPTH];
  logic [WIDTH-1:0]  data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (meta_we) meta_mem[meta_idx] <= {meta_addr, meta_size, meta_signext, meta_tag};
    if (data_we) data_mem[data_idx] <= data_in;
  end

  assign {rd_addr, rd_size, rd_signext, rd_tag} = meta_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/vload_resp_tracker.sv
// Tracks outstanding vector load requests and pairs in-order memory responses
// with their saved metadata, presenting them in issue order to the translator.
module vload_resp_tracker
  import vload_resp_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PTRW  = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [SIZE_W-1:0] issue_size,
  input  logic              issue_signext,
  input  logic [TAGW-1:0]   issue_tag,
  input  logic              mem_rdvalid,
  input  logic [WIDTH-1:0]  mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_readdata,
  output logic [ADDR_W-1:0] out_addr,
  output logic [SIZE_W-1:0] out_size,
  output logic              out_signext,
  output logic [TAGW-1:0]   out_tag,
  output logic [PTRW:0]     outstanding,
  output logic              resp_err
);

  localparam int unsigned   DEPTH    = 1 << PTRW;
  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] PTR_ONE  = (PTRW+1)'(1);

  logic [PTRW:0]     wr_ptr, fill_ptr, rd_ptr;
  logic [PTRW:0]     occupancy, awaiting;
  logic [DEPTH-1:0]  filled;
  logic [PTRW-1:0]   wr_idx, fill_idx, rd_idx;
  logic              issue_fire, fill_fire, pop_fire, stray_resp;

  assign wr_idx   = wr_ptr[PTRW-1:0];
  assign fill_idx = fill_ptr[PTRW-1:0];
  assign rd_idx   = rd_ptr[PTRW-1:0];

  assign occupancy = wr_ptr - rd_ptr;
  assign awaiting  = wr_ptr - fill_ptr;

  assign issue_ready = (occupancy != FULL_CNT);
  assign out_valid   = (occupancy != '0) && filled[rd_idx];
  assign outstanding = occupancy;

  assign issue_fire = issue_valid & issue_ready;
  assign fill_fire  = mem_rdvalid && (awaiting != '0);
  assign stray_resp = mem_rdvalid && (awaiting == '0);
  assign pop_fire   = out_valid & out_ready;

  // Issue and fill never target the same index in one cycle: a fill needs
  // awaiting != 0 and an issue needs occupancy != DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      filled   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (issue_fire) begin
        wr_ptr         <= wr_ptr + PTR_ONE;
        filled[wr_idx] <= 1'b0;
      end
      if (fill_fire) begin
        fill_ptr         <= fill_ptr + PTR_ONE;
        filled[fill_idx] <= 1'b1;
      end
      if (stray_resp) resp_err <= 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  vload_tracker_ram #(
    .WIDTH (WIDTH),
    .PTRW  (PTRW),
    .TAGW  (TAGW)
  ) u_ram (
    .clk          (clk),
    .meta_we      (issue_fire),
    .meta_idx     (wr_idx),
    .meta_addr    (issue_addr),
    .meta_size    (issue_size),
    .meta_signext (issue_signext),
    .meta_tag     (issue_tag),
    .data_we      (fill_fire),
    .data_idx     (fill_idx),
    .data_in      (mem_readdata),
    .rd_idx       (rd_idx),
    .rd_data      (out_readdata),
    .rd_addr      (out_addr),
    .rd_size      (out_size),
    .rd_signext   (out_signext),
    .rd_tag       (out_tag)
  );

endmodule

// File: tb/tb_vload_resp_tracker.sv
// Self-checking bench for vload_resp_tracker: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_vload_resp_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_addr;
  logic [1:0]  issue_size;
  logic        issue_signext;
  logic [4:0]  issue_tag;
  logic        mem_rdvalid;
  logic [31:0] mem_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_readdata;
  logic [1:0]  out_addr;
  logic [1:0]  out_size;
  logic        out_signext;
  logic [4:0]  out_tag;
  logic [2:0]  outstanding;
  logic        resp_err;

  vload_resp_tracker #(
    .WIDTH (32),
    .PTRW  (2),
    .TAGW  (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_addr    (issue_addr),
    .issue_size    (issue_size),
    .issue_signext (issue_signext),
    .issue_tag     (issue_tag),
    .mem_rdvalid   (mem_rdvalid),
    .mem_readdata  (mem_readdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_readdata  (out_readdata),
    .out_addr      (out_addr),
    .out_size      (out_size),
    .out_signext   (out_signext),
    .out_tag       (out_tag),
    .outstanding   (outstanding),
    .resp_err      (resp_err)
  );

  always #5 clk = ~clk;

  // Reference model: allocated, not-yet-popped loads in issue order. Responses
  // fill in order, so the first n_filled entries hold data.
  typedef struct {
    logic [1:0]  addr;
    logic [1:0]  size;
    logic        sx;
    logic [4:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_filled;
  bit   m_err;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("issue_ready", 32'(issue_ready), 32'(q.size() != 4));
    chk("out_valid",   32'(out_valid),   32'(n_filled > 0));
    chk("resp_err",    32'(resp_err),    32'(m_err));
    if (n_filled > 0) begin
      chk("out_readdata", out_readdata,      q[0].data);
      chk("out_addr",     32'(out_addr),     32'(q[0].addr));
      chk("out_size",     32'(out_size),     32'(q[0].size));
      chk("out_signext",  32'(out_signext),  32'(q[0].sx));
      chk("out_tag",      32'(out_tag),      32'(q[0].tag));
    end
  endtask

  task automatic model_clear();
    q.delete();
    n_filled = 0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare mid-cycle, then advance the model
  // on the rising edge using the pre-edge state.
  task automatic step(input bit iv, input logic [1:0] a, input logic [1:0] s, input bit sx,
                      input logic [4:0] t, input bit rv, input logic [31:0] d, input bit ordy);
    bit   do_issue, do_fill, do_pop;
    ent_t e;
    issue_valid   = iv;
    issue_addr    = a;
    issue_size    = s;
    issue_signext = sx;
    issue_tag     = t;
    mem_rdvalid   = rv;
    mem_readdata  = d;
    out_ready     = ordy;
    @(negedge clk);
    check_model();
    @(posedge clk);
    do_issue = iv && (q.size() < 4);
    do_fill  = rv && (q.size() - n_filled != 0);
    do_pop   = ordy && (n_filled > 0);
    if (rv && !do_fill) m_err = 1'b1;
    if (do_fill) begin
      q[n_filled].data = d;
      n_filled++;
    end
    if (do_pop) begin
      void'(q.pop_front());
      n_filled--;
    end
    if (do_issue) begin
      e.addr = a; e.size = s; e.sx = sx; e.tag = t; e.data = 32'h0;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic issue(input logic [1:0] a, input logic [1:0] s, input bit sx, input logic [4:0] t);
    step(1'b1, a, s, sx, t, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] d, input bit ordy);
    step(1'b0, 2'b0, 2'b0, 1'b0, 5'd0, 1'b1, d, ordy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 2'b0, 2'b0, 1'b0, 5'd0, 1'b0, 32'h0, ordy);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    issue_valid = 1'b0;
    mem_rdvalid = 1'b0;
    out_ready   = 1'b0;
    reset       = 1'b1;
    #1;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_resp_err",    32'(resp_err),    32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; issue_valid = 1'b0; issue_addr = '0; issue_size = '0;
    issue_signext = 1'b0; issue_tag = '0; mem_rdvalid = 1'b0; mem_readdata = '0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Single load, response two cycles after issue, visible one cycle later.
    issue(2'd2, 2'b00, 1'b1, 5'd3);
    idle(1'b0);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    resp(32'h12345678, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_readdata", out_readdata, 32'h12345678);
    chk("t1_addr", 32'(out_addr), 32'd2);
    chk("t1_tag", 32'(out_tag), 32'd3);
    idle(1'b1);

    // Fill to capacity; a fifth issue is refused.
    for (int i = 0; i < 4; i++) issue(2'(i), 2'b10, 1'b0, 5'(10 + i));
    chk("full_issue_ready", 32'(issue_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    issue(2'd1, 2'b01, 1'b1, 5'd31);
    for (int i = 0; i < 4; i++) resp(32'hC0DE_0000 + 32'(i), 1'b0);
    chk("full_still_blocked", 32'(issue_ready), 32'd0);
    idle(1'b1);
    chk("full_ready_after_pop", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("full_drained", 32'(outstanding), 32'd0);

    // Stalled consumer, then back-to-back pops in tag order.
    for (int i = 1; i <= 3; i++) issue(2'd0, 2'b10, 1'b0, 5'(i));
    resp(32'hA, 1'b0);
    resp(32'hB, 1'b0);
    resp(32'hC, 1'b0);
    idle(1'b0);
    idle(1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk("order_tag", 32'(out_tag), 32'(i));
      chk("order_data", out_readdata, 32'(9 + i));
      idle(1'b1);
    end
    chk("order_empty", 32'(out_valid), 32'd0);

    // Occupancy 2 (head filled, second awaiting): issue+fill+pop together.
    issue(2'd1, 2'b01, 1'b0, 5'd20);
    issue(2'd3, 2'b00, 1'b1, 5'd21);
    resp(32'h0000_1111, 1'b0);
    step(1'b1, 2'd2, 2'b10, 1'b0, 5'd22, 1'b1, 32'h0000_2222, 1'b1);
    chk("simul_occupancy", 32'(outstanding), 32'd2);
    chk("simul_head_tag", 32'(out_tag), 32'd21);
    resp(32'h0000_3333, 1'b1);
    idle(1'b1);
    chk("simul_drained", 32'(outstanding), 32'd0);

    // Stray response: dropped and flagged.
    resp(32'hDEAD_BEEF, 1'b0);
    chk("stray_resp_err", 32'(resp_err), 32'd1);
    chk("stray_out_valid", 32'(out_valid), 32'd0);
    idle(1'b0);

    // Reset with three outstanding, then a late response.
    do_reset();
    for (int i = 0; i < 3; i++) issue(2'(i), 2'b00, 1'b0, 5'(i));
    chk("pre_rst_outstanding", 32'(outstanding), 32'd3);
    do_reset();
    resp(32'h5555_AAAA, 1'b0);
    chk("late_resp_err", 32'(resp_err), 32'd1);
    idle(1'b0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit rv;
      if (q.size() - n_filled != 0) rv = ($urandom_range(0, 99) < 55);
      else                          rv = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 99) < 60), 2'($urandom), 2'($urandom), 1'($urandom),
           5'($urandom), rv, $urandom, ($urandom_range(0, 99) < 60));
    end
    for (int n = 0; n < 8; n++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
